reg_file_param: RTL



---
 rtl/reg_file_param_pkg.sv | 16 +
 rtl/reg_file_param_word.sv | 26 ++
 rtl/reg_file_param.sv | 86 ++++++++
 3 files changed

// File: rtl/reg_file_param_pkg.sv
// Shared constants, types and helpers for the parametrised register file.
package reg_file_param_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 32;

  typedef logic [DefaultWidth-1:0] word_t;

  localparam word_t WordZero = '0;

  // Address width for a given entry count; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_param_word.sv
// Load-enabled word register with synchronous active-high reset (module reg_word_sr).
module reg_word_sr
  import reg_file_param_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= WIDTH'(WordZero);
    end else if (load_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_file_param.sv
// WIDTH x DEPTH register file: one synchronous write port, two registered read ports.
// Define REG_FILE_PARAM_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter bit          ZERO_REG0 = 1'b1,
  localparam int unsigned AW       = addr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA_W,
  input  logic [AW-1:0]    ADDR_W,
  input  logic             WRITE,
  input  logic [AW-1:0]    ADDR_R1,
  input  logic [AW-1:0]    ADDR_R2,
  input  logic             READ,
  output logic [WIDTH-1:0] DATA_R1,
  output logic [WIDTH-1:0] DATA_R2
);

  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] entry_q  [DEPTH];
  logic [WIDTH-1:0] read_src [DEPTH];
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;

  // One-hot write decode; out-of-range addresses match no entry and are dropped.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wr_en[i] = WRITE && (ADDR_W == AW'(i)) && !(ZERO_REG0 && (i == 0));

    reg_word_sr #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk_i  (CLK),
      .reset_i(RESET),
      .load_i (wr_en[i]),
      .d_i    (DATA_W),
      .q_o    (entry_q[i])
    );

`ifdef REG_FILE_PARAM_BYPASS_EN
    assign read_src[i] = wr_en[i] ? DATA_W : entry_q[i];
`else
    assign read_src[i] = entry_q[i];
`endif
  end

  // DEPTH:1 read muxes; hardwired-zero entry and out-of-range addresses yield 0.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG0 && (i == 0))) begin
        if (ADDR_R1 == AW'(i)) begin
          rd1_d = read_src[i];
        end
        if (ADDR_R2 == AW'(i)) begin
          rd2_d = read_src[i];
        end
      end
    end
  end

  reg_word_sr #(
    .WIDTH(WIDTH)
  ) u_rd1 (
    .clk_i  (CLK),
    .reset_i(RESET),
    .load_i (READ),
    .d_i    (rd1_d),
    .q_o    (DATA_R1)
  );

  reg_word_sr #(
    .WIDTH(WIDTH)
  ) u_rd2 (
    .clk_i  (CLK),
    .reset_i(RESET),
    .load_i (READ),
    .d_i    (rd2_d),
    .q_o    (DATA_R2)
  );

endmodule
